packet_link_scheduler: RTL and testbench
========================================

Name: packet_link_scheduler

Overview:
- Shares one outgoing NIC link between N_CHANNEL virtual-channel FIFOs.
- Round-robin arbitration at packet boundaries; once a head flit wins, the channel holds the link until its tail flit (wormhole lock).
- Keeps per-channel credit counters for downstream VC buffers; a channel is eligible only with credit > 0.
- Sits between the VC FIFO heads and the link output register; drives FIFO pops and the link mux select.

Parameters:
- N_CHANNEL, 6, number of requesting VCs / FIFOs.
- N_BITS_POINTER, 3, width of channel index; must satisfy 2^N_BITS_POINTER >= N_CHANNEL.
- N_CREDIT, 4, downstream buffer depth per VC; credit counter reset value.
- N_BITS_CREDIT, 3, credit counter width; must hold the value N_CREDIT.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- r_i  input  N_CHANNEL  bit i high: FIFO i has a valid flit at head.
- tail_i  input  N_CHANNEL  bit i high: head flit of FIFO i is a tail; single-flit packet = head+tail.
- link_ready_i  input  1  link stage accepts a flit this cycle.
- credit_i  input  N_CHANNEL  one-cycle pulse per returned downstream credit for VC i.
- g_o  output  1  flit transfers this cycle (combinational).
- g_channel_id_o  output  N_BITS_POINTER  channel transferring; holds last_served when g_o=0.
- pop_o  output  N_CHANNEL  one-hot pop, equal to g_o ? onehot(g_channel_id_o) : 0.
- busy_o  output  1  registered; high while state=LOCKED.
- credit_err_o  output  1  registered sticky; credit returned to a full counter.

Behaviour:
- Eligibility: elig[i] = r_i[i] & (credit[i] != 0).
- States: IDLE, LOCKED(owner). Reset -> IDLE, owner=0, last_served=N_CHANNEL-1, credit[i]=N_CREDIT, busy_o=0, credit_err_o=0. While rst=1, g_o=0 and pop_o=0 regardless of inputs.
- IDLE grant: if link_ready_i & |elig, winner = first eligible channel searching last_served+1, +2, … wrapping modulo N_CHANNEL, with last_served searched last (lowest priority). g_o=1, g_channel_id_o=winner, same cycle (zero latency).
- IDLE, winner flit not tail -> LOCKED with owner=winner. Winner flit tail (single-flit packet) -> stay IDLE; last_served<=winner.
- LOCKED: only owner considered. g_o = link_ready_i & elig[owner]. Other requests are ignored. Owner bubble (r_i low or no credit) -> g_o=0, stay LOCKED, no timeout.
- LOCKED, transfer of a tail flit -> IDLE next cycle; last_served<=owner.
- A new packet can win in the cycle right after a tail, with no dead cycle.
- link_ready_i=0: no grant, no state, pointer or credit change.
- Credit update per channel each cycle:
  - grant only: -1.
  - credit_i only: +1.
  - both: unchanged.
  - credit_i at N_CREDIT with no grant: counter stays N_CREDIT, credit_err_o<=1 until rst.
  - The grant path never decrements at 0, because eligibility excludes it.
- Pointer wrap: index N_CHANNEL-1 +1 -> 0. Indices >= N_CHANNEL are never produced.
- Reset mid-packet: return to IDLE, lose the lock, restore all credits. The upstream side is responsible for flushing.

Decomposition:
- Shared package (nic_pkg): state encoding localparams (ST_IDLE, ST_LOCKED), credit width helper constant.
- Sub-module credit_counter: one per channel via generate; ports clk, rst, dec, inc, nonzero, overflow.
- Round-robin search and FSM stay in the top.

Test Plan:
- After reset, r_i=6'b000011, all tails, link_ready_i=1 -> grants ch0, ch1, ch0, ch1 on consecutive cycles; busy_o stays 0.
- Ch2 sends a 3-flit packet (tail on flit 3) while ch4 requests continuously -> g_channel_id_o=2 for 3 cycles, busy_o=1 for cycles 2–3, ch4 granted in cycle 4.
- Ch0 streams single-flit packets with no credit_i -> exactly 4 grants, then g_o=0. A credit_i[0] pulse -> one further grant the next cycle.
- Grant and credit_i[3] in the same cycle at credit=2 -> credit stays 2. credit_i[3] with credit=4 -> credit_err_o=1 next cycle, credit stays 4.
- Mid-packet on ch1: link_ready_i=0 for 2 cycles, then ch1 r_i low for 1 cycle -> g_o=0 during those cycles, LOCKED held, ch5 request never granted until ch1's tail.
- rst asserted while LOCKED on ch3 with credit[3]=1 -> next cycle busy_o=0, credit[3]=4, first grant goes to the lowest eligible index from 0.

Source files
------------

// File: rtl/nic_pkg.sv
// rtl/nic_pkg.sv - shared state encoding and credit sizing for the link scheduler
package nic_pkg;
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam int N_CREDIT_DEF      = 4;
  localparam int N_BITS_CREDIT_DEF = $clog2(N_CREDIT_DEF + 1);
endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - per-VC downstream credit counter with overflow detect
module credit_counter
  import nic_pkg::*;
#(
  parameter int N_CREDIT      = N_CREDIT_DEF,
  parameter int N_BITS_CREDIT = N_BITS_CREDIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dec,
  input  logic inc,
  output logic nonzero,
  output logic overflow
);
  logic [N_BITS_CREDIT-1:0] cnt_q, cnt_d;
  logic                     full;

  assign full     = (cnt_q == N_BITS_CREDIT'(N_CREDIT));
  assign nonzero  = (cnt_q != '0);
  assign overflow = inc & ~dec & full;

  // A credit returning to a full counter is dropped; the top flags it.
  always_comb begin
    cnt_d = cnt_q;
    if (dec && !inc) begin
      cnt_d = cnt_q - 1'b1;
    end else if (inc && !dec && !full) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= N_BITS_CREDIT'(N_CREDIT);
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/packet_link_scheduler.sv
// rtl/packet_link_scheduler.sv - round-robin wormhole arbiter for one NIC link
module packet_link_scheduler
  import nic_pkg::*;
#(
  parameter int N_CHANNEL      = 6,
  parameter int N_BITS_POINTER = 3,
  parameter int N_CREDIT       = 4,
  parameter int N_BITS_CREDIT  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CHANNEL-1:0]      r_i,
  input  logic [N_CHANNEL-1:0]      tail_i,
  input  logic                      link_ready_i,
  input  logic [N_CHANNEL-1:0]      credit_i,
  output logic                      g_o,
  output logic [N_BITS_POINTER-1:0] g_channel_id_o,
  output logic [N_CHANNEL-1:0]      pop_o,
  output logic                      busy_o,
  output logic                      credit_err_o
);
  localparam int PW = N_BITS_POINTER + 1;

  state_e                    state_q, state_d;
  logic [N_BITS_POINTER-1:0] owner_q, owner_d;
  logic [N_BITS_POINTER-1:0] last_q, last_d;
  logic                      credit_err_q;
  logic [N_CHANNEL-1:0]      nonzero, overflow, elig;
  logic                      found;
  logic [N_BITS_POINTER-1:0] winner;
  logic [PW-1:0]             cand;

  assign elig = r_i & nonzero;

  for (genvar i = 0; i < N_CHANNEL; i++) begin : g_credit
    credit_counter #(
      .N_CREDIT      (N_CREDIT),
      .N_BITS_CREDIT (N_BITS_CREDIT)
    ) u_credit (
      .clk      (clk),
      .rst      (rst),
      .dec      (pop_o[i]),
      .inc      (credit_i[i]),
      .nonzero  (nonzero[i]),
      .overflow (overflow[i])
    );
    assign pop_o[i] = g_o && (g_channel_id_o == N_BITS_POINTER'(i));
  end

  // Search order starts just after last_served so it is considered last.
  always_comb begin
    found  = 1'b0;
    winner = last_q;
    cand   = '0;
    for (int k = 1; k <= N_CHANNEL; k++) begin
      cand = {1'b0, last_q} + PW'(k);
      if (cand >= PW'(N_CHANNEL)) begin
        cand = cand - PW'(N_CHANNEL);
      end
      if (!found && elig[cand[N_BITS_POINTER-1:0]]) begin
        found  = 1'b1;
        winner = cand[N_BITS_POINTER-1:0];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_d         = last_q;
    g_o            = 1'b0;
    g_channel_id_o = last_q;
    if (!rst && link_ready_i) begin
      case (state_q)
        ST_IDLE: begin
          if (found) begin
            g_o            = 1'b1;
            g_channel_id_o = winner;
            if (tail_i[winner]) begin
              last_d = winner;
            end else begin
              state_d = ST_LOCKED;
              owner_d = winner;
            end
          end
        end
        ST_LOCKED: begin
          if (elig[owner_q]) begin
            g_o            = 1'b1;
            g_channel_id_o = owner_q;
            if (tail_i[owner_q]) begin
              state_d = ST_IDLE;
              last_d  = owner_q;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      last_q       <= N_BITS_POINTER'(N_CHANNEL - 1);
      credit_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_q       <= last_d;
      credit_err_q <= credit_err_q | (|overflow);
    end
  end

  assign busy_o       = (state_q == ST_LOCKED);
  assign credit_err_o = credit_err_q;
endmodule

// File: tb/tb_packet_link_scheduler.sv
// tb/tb_packet_link_scheduler.sv - directed scoreboard bench for packet_link_scheduler
module tb_packet_link_scheduler;
  logic       clk;
  logic       rst;
  logic [5:0] r_i, tail_i, credit_i;
  logic       link_ready_i;
  logic       g_o;
  logic [2:0] g_channel_id_o;
  logic [5:0] pop_o;
  logic       busy_o;
  logic       credit_err_o;

  typedef struct packed {
    logic       g;
    logic [2:0] id;
    logic       busy;
    logic       err;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   step   = 0;
  logic exp_err;

  packet_link_scheduler #(
    .N_CHANNEL      (6),
    .N_BITS_POINTER (3),
    .N_CREDIT       (4),
    .N_BITS_CREDIT  (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .r_i            (r_i),
    .tail_i         (tail_i),
    .link_ready_i   (link_ready_i),
    .credit_i       (credit_i),
    .g_o            (g_o),
    .g_channel_id_o (g_channel_id_o),
    .pop_o          (pop_o),
    .busy_o         (busy_o),
    .credit_err_o   (credit_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare_head();
    exp_t       e;
    logic [5:0] exp_pop;
    e       = sb.pop_front();
    exp_pop = e.g ? (6'b000001 << e.id) : 6'b000000;
    checks++;
    assert (g_o === e.g) else begin
      errors++;
      $error("FAIL g step=%0d got=%b exp=%b", step, g_o, e.g);
    end
    checks++;
    assert (g_channel_id_o === e.id) else begin
      errors++;
      $error("FAIL id step=%0d got=%0d exp=%0d", step, g_channel_id_o, e.id);
    end
    checks++;
    assert (pop_o === exp_pop) else begin
      errors++;
      $error("FAIL pop step=%0d got=%b exp=%b", step, pop_o, exp_pop);
    end
    checks++;
    assert (busy_o === e.busy) else begin
      errors++;
      $error("FAIL busy step=%0d got=%b exp=%b", step, busy_o, e.busy);
    end
    checks++;
    assert (credit_err_o === e.err) else begin
      errors++;
      $error("FAIL err step=%0d got=%b exp=%b", step, credit_err_o, e.err);
    end
  endtask

  // Drive one cycle of inputs, queue the expectation, compare at the falling edge.
  task automatic cyc(input logic [5:0] r, input logic [5:0] t, input logic lr,
                     input logic [5:0] cr, input logic eg, input int eid, input logic eb);
    exp_t e;
    r_i          = r;
    tail_i       = t;
    link_ready_i = lr;
    credit_i     = cr;
    e.g          = eg;
    e.id         = 3'(eid);
    e.busy       = eb;
    e.err        = exp_err;
    sb.push_back(e);
    step++;
    @(negedge clk);
    compare_head();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_err      = 1'b0;
    rst          = 1'b1;
    r_i          = 6'b111111;
    tail_i       = 6'b111111;
    link_ready_i = 1'b1;
    credit_i     = 6'b000000;
    repeat (2) @(posedge clk);
    #1;
    // reset holds off grants even with every channel requesting
    cyc(6'b111111, 6'b111111, 1'b1, 6'b000000, 1'b0, 5, 1'b0);
    rst = 1'b0;

    // alternating single-flit packets on ch0/ch1
    cyc(6'b000011, 6'b111111, 1'b1, 6'b000000, 1'b1, 0, 1'b0);
    cyc(6'b000011, 6'b111111, 1'b1, 6'b000000, 1'b1, 1, 1'b0);
    cyc(6'b000011, 6'b111111, 1'b1, 6'b000000, 1'b1, 0, 1'b0);
    cyc(6'b000011, 6'b111111, 1'b1, 6'b000000, 1'b1, 1, 1'b0);

    // ch2 three-flit packet locks out ch4
    cyc(6'b010100, 6'b010000, 1'b1, 6'b000000, 1'b1, 2, 1'b0);
    cyc(6'b010100, 6'b010000, 1'b1, 6'b000000, 1'b1, 2, 1'b1);
    cyc(6'b010100, 6'b010100, 1'b1, 6'b000000, 1'b1, 2, 1'b1);
    cyc(6'b010000, 6'b010000, 1'b1, 6'b000000, 1'b1, 4, 1'b0);

    // refill ch0 to 4, then drain it to zero credit
    cyc(6'b000000, 6'b111111, 1'b1, 6'b000001, 1'b0, 4, 1'b0);
    cyc(6'b000000, 6'b111111, 1'b1, 6'b000001, 1'b0, 4, 1'b0);
    for (int n = 0; n < 4; n++) begin
      cyc(6'b000001, 6'b111111, 1'b1, 6'b000000, 1'b1, 0, 1'b0);
    end
    cyc(6'b000001, 6'b111111, 1'b1, 6'b000000, 1'b0, 0, 1'b0);
    cyc(6'b000001, 6'b111111, 1'b1, 6'b000001, 1'b0, 0, 1'b0);
    cyc(6'b000001, 6'b111111, 1'b1, 6'b000000, 1'b1, 0, 1'b0);
    cyc(6'b000001, 6'b111111, 1'b1, 6'b000000, 1'b0, 0, 1'b0);

    // ch3: grant with simultaneous credit return leaves credit at 2
    cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b1, 3, 1'b0);
    cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b1, 3, 1'b0);
    cyc(6'b001000, 6'b111111, 1'b1, 6'b001000, 1'b1, 3, 1'b0);
    cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b1, 3, 1'b0);
    cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b1, 3, 1'b0);
    cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b0, 3, 1'b0);

    // ch3 refill to full, then one extra credit overflows
    for (int n = 0; n < 4; n++) begin
      cyc(6'b000000, 6'b111111, 1'b1, 6'b001000, 1'b0, 3, 1'b0);
    end
    cyc(6'b000000, 6'b111111, 1'b1, 6'b001000, 1'b0, 3, 1'b0);
    exp_err = 1'b1;
    for (int n = 0; n < 4; n++) begin
      cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b1, 3, 1'b0);
    end
    cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b0, 3, 1'b0);

    // ch1 packet with link stalls and an owner bubble; ch5 must wait
    cyc(6'b000010, 6'b000000, 1'b1, 6'b000000, 1'b1, 1, 1'b0);
    cyc(6'b100010, 6'b000000, 1'b0, 6'b000000, 1'b0, 3, 1'b1);
    cyc(6'b100010, 6'b000000, 1'b0, 6'b000000, 1'b0, 3, 1'b1);
    cyc(6'b100000, 6'b000000, 1'b1, 6'b000000, 1'b0, 3, 1'b1);
    cyc(6'b100010, 6'b000010, 1'b1, 6'b000000, 1'b1, 1, 1'b1);
    cyc(6'b100000, 6'b100000, 1'b1, 6'b000000, 1'b1, 5, 1'b0);

    // lock ch3 at credit 1, then reset mid-packet
    cyc(6'b000000, 6'b111111, 1'b1, 6'b001000, 1'b0, 5, 1'b0);
    cyc(6'b000000, 6'b111111, 1'b1, 6'b001000, 1'b0, 5, 1'b0);
    cyc(6'b001000, 6'b000000, 1'b1, 6'b000000, 1'b1, 3, 1'b0);
    cyc(6'b000000, 6'b000000, 1'b1, 6'b000000, 1'b0, 5, 1'b1);
    rst = 1'b1;
    cyc(6'b111111, 6'b111111, 1'b1, 6'b000000, 1'b0, 5, 1'b1);
    rst     = 1'b0;
    exp_err = 1'b0;
    cyc(6'b001001, 6'b001001, 1'b1, 6'b000000, 1'b1, 0, 1'b0);
    for (int n = 0; n < 4; n++) begin
      cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b1, 3, 1'b0);
    end
    cyc(6'b001000, 6'b111111, 1'b1, 6'b000000, 1'b0, 3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
